// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: buffers an MxM image and NxN kernel from a handshaked stream,
// then emits the zero-padded "same" convolution one result per accepted output cycle.
module conv2d_stream_engine #(
    parameter int M      = 4,
    parameter int N      = 3,
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 3,
    parameter int OW     = WIDTH1 + WIDTH2 + N * N - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode_signed,
    input  logic [WIDTH1-1:0] img_in,
    input  logic [WIDTH2-1:0] kernel_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_data,
    output logic              out_last,
    output logic              busy
);
    localparam int MM = M * M;
    localparam int NN = N * N;
    localparam int ZP = (N - 1) / 2;
    localparam int PW = $clog2(MM);
    localparam logic [PW-1:0] LAST = PW'(MM - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d, p_q, p_d;
    logic [WIDTH1-1:0] img_q [MM];
    logic [WIDTH1-1:0] img_d [MM];
    logic [WIDTH2-1:0] ker_q [NN];
    logic [WIDTH2-1:0] ker_d [NN];
    logic              mode_q, mode_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [OW-1:0]     out_data_q, out_data_d, acc, pix_x, ker_x;
    logic              accept, fire;
    int                r, c;

    assign in_ready  = state_q != CALC;
    assign busy      = state_q != IDLE;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // The result for p_d is computed from next-state buffers so the first output is ready right after the last beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        img_d   = img_q;
        ker_d   = ker_q;
        mode_d  = mode_q;
        r       = 0;
        c       = 0;
        pix_x   = '0;
        ker_x   = '0;
        if (accept) begin
            img_d[cnt_q] = img_in;
            if (int'(cnt_q) < NN) ker_d[cnt_q] = kernel_in;
            if (state_q == IDLE) mode_d = mode_signed;
            cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == LAST ? CALC : LOAD;
            p_d     = '0;
        end
        if (fire) begin
            p_d     = p_q == LAST ? '0 : p_q + 1'b1;
            state_d = p_q == LAST ? IDLE : CALC;
        end
        acc = '0;
        for (int k = 0; k < N; k++) begin
            for (int h = 0; h < N; h++) begin
                r     = int'(p_d) / M + k - ZP;
                c     = int'(p_d) % M + h - ZP;
                pix_x = (r >= 0 && r < M && c >= 0 && c < M) ? OW'(img_d[r * M + c]) : '0;
                ker_x = mode_d ? {{(OW - WIDTH2){ker_d[k * N + h][WIDTH2-1]}}, ker_d[k * N + h]}
                               : OW'(ker_d[k * N + h]);
                acc   = acc + pix_x * ker_x;
            end
        end
        out_valid_d = state_d == CALC;
        out_last_d  = state_d == CALC && p_d == LAST;
        out_data_d  = state_d == CALC ? acc : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < MM; i++) img_q[i] <= '0;
            for (int i = 0; i < NN; i++) ker_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            img_q       <= img_d;
            ker_q       <= ker_d;
        end
    end
endmodule
